// File: rtl/cmsdk_swd_pkg.sv
// rtl/cmsdk_swd_pkg.sv - SWD host shared constants, FSM encoding and helpers (LRST state under CMSDK_SWD_HOST_LINE_RESET_EN)
package cmsdk_swd_pkg;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    localparam logic [5:0] LEN_REQ  = 6'd8;
    localparam logic [5:0] LEN_TRN  = 6'd1;
    localparam logic [5:0] LEN_ACK  = 6'd3;
    localparam logic [5:0] LEN_DATA = 6'd33;
    localparam logic [5:0] LEN_TAIL = 6'd2;
    localparam logic [5:0] LEN_LRST = 6'd56;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_REQ   = 4'd1,
        ST_TRN1  = 4'd2,
        ST_ACK   = 4'd3,
        ST_RDATA = 4'd4,
        ST_TRN2  = 4'd5,
        ST_WDATA = 4'd6,
        ST_TAIL  = 4'd7,
        ST_RESP  = 4'd8
`ifdef CMSDK_SWD_HOST_LINE_RESET_EN
        ,
        ST_LRST  = 4'd9
`endif
    } swd_state_t;

    // Number of bit periods spent in each wire phase.
    function automatic logic [5:0] phase_len(input swd_state_t st);
        case (st)
            ST_REQ:   phase_len = LEN_REQ;
            ST_ACK:   phase_len = LEN_ACK;
            ST_RDATA: phase_len = LEN_DATA;
            ST_WDATA: phase_len = LEN_DATA;
            ST_TAIL:  phase_len = LEN_TAIL;
`ifdef CMSDK_SWD_HOST_LINE_RESET_EN
            ST_LRST:  phase_len = LEN_LRST;
`endif
            default:  phase_len = LEN_TRN;
        endcase
    endfunction

    // Packet request header, bit 0 goes on the wire first.
    function automatic logic [7:0] req_header(input logic apndp, input logic rnw, input logic [1:0] addr);
        req_header = {1'b1, 1'b0, apndp ^ rnw ^ addr[0] ^ addr[1], addr[1], addr[0], rnw, apndp, 1'b1};
    endfunction

endpackage

// File: rtl/cmsdk_swd_clkgen.sv
// rtl/cmsdk_swd_clkgen.sv - SWCLK divider producing swclk_o plus fall/rise strobes
module cmsdk_swd_clkgen #(
    parameter int CLKDIV = 4
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic run,
    output logic swclk_o,
    output logic fall_stb,
    output logic rise_stb
);

    localparam logic [8:0] RISE_AT = 9'(CLKDIV - 1);
    localparam logic [8:0] FALL_AT = 9'(2 * CLKDIV - 1);

    logic [8:0] cnt_q;
    logic       swclk_q;

    // Strobes mark the edge on which swclk rises (sample) and falls (next bit).
    assign rise_stb = run && (cnt_q == RISE_AT);
    assign fall_stb = run && (cnt_q == FALL_AT);
    assign swclk_o  = swclk_q;

    // Position within the current bit period; parked at zero while idle.
    always_ff @(posedge HCLK) begin
        if (HRESET || !run) begin
            cnt_q <= '0;
        end else if (fall_stb) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 9'd1;
        end
    end

    // SWCLK: low for the first half of each period, high for the second.
    always_ff @(posedge HCLK) begin
        if (HRESET || !run) begin
            swclk_q <= 1'b0;
        end else if (rise_stb) begin
            swclk_q <= 1'b1;
        end else if (fall_stb) begin
            swclk_q <= 1'b0;
        end
    end

endmodule

// File: rtl/cmsdk_swd_host.sv
// rtl/cmsdk_swd_host.sv - SWD host packet engine; line reset support under CMSDK_SWD_HOST_LINE_RESET_EN
module cmsdk_swd_host
    import cmsdk_swd_pkg::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_apndp,
    input  logic        req_rnw,
    input  logic [1:0]  req_addr,
    input  logic [31:0] req_wdata,
`ifdef CMSDK_SWD_HOST_LINE_RESET_EN
    input  logic        req_lrst,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_perr,
    output logic        swclk_o,
    output logic        swdio_o,
    output logic        swdio_oe,
    input  logic        swdio_i
);

    swd_state_t  state_q;
    logic [5:0]  bit_q;
    logic [7:0]  hdr_q;
    logic        rnw_q;
    logic [31:0] wdata_q;
    logic        wpar_q;
    logic [2:0]  ack_q;
    logic [31:0] rdata_q;
    logic        rpar_q;
    logic        swdio_o_q;
    logic        swdio_oe_q;
    logic        rsp_valid_q;
    logic [2:0]  rsp_ack_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_perr_q;

    logic        run;
    logic        fall_stb;
    logic        rise_stb;
    logic        last_bit;
    logic        read_ok;
    swd_state_t  nxt_state;
    swd_state_t  drv_st;
    logic [5:0]  drv_idx;
    logic        drv_o;
    logic        drv_oe;

    assign run       = (state_q != ST_IDLE) && (state_q != ST_RESP);
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_ack   = rsp_ack_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_perr  = rsp_perr_q;
    assign swdio_o   = swdio_o_q;
    assign swdio_oe  = swdio_oe_q;

    cmsdk_swd_clkgen #(
        .CLKDIV (CLKDIV)
    ) u_clkgen (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .run      (run),
        .swclk_o  (swclk_o),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    // Phase sequencing and the line value for the bit that starts at the next fall.
    always_comb begin
        last_bit  = (bit_q == phase_len(state_q) - 6'd1);
        read_ok   = (ack_q == ACK_OK) && rnw_q;
        nxt_state = ST_IDLE;
        case (state_q)
            ST_REQ:   nxt_state = ST_TRN1;
            ST_TRN1:  nxt_state = ST_ACK;
            ST_ACK:   nxt_state = read_ok ? ST_RDATA : ST_TRN2;
            ST_RDATA: nxt_state = ST_TRN2;
            ST_TRN2:  nxt_state = ((ack_q == ACK_OK) && !rnw_q) ? ST_WDATA : ST_TAIL;
            ST_WDATA: nxt_state = ST_TAIL;
`ifdef CMSDK_SWD_HOST_LINE_RESET_EN
            ST_LRST:  nxt_state = ST_TAIL;
`endif
            ST_TAIL:  nxt_state = ST_RESP;
            default:  nxt_state = ST_IDLE;
        endcase

        drv_st  = last_bit ? nxt_state : state_q;
        drv_idx = last_bit ? 6'd0 : (bit_q + 6'd1);
        drv_o   = 1'b0;
        drv_oe  = 1'b1;
        case (drv_st)
            ST_REQ:   drv_o = hdr_q[drv_idx[2:0]];
            ST_TRN1,
            ST_ACK,
            ST_RDATA: drv_oe = 1'b0;
            // Turnaround after read data: the target still owns the line.
            ST_TRN2:  drv_oe = !read_ok;
            ST_WDATA: drv_o = (drv_idx == 6'd32) ? wpar_q : wdata_q[drv_idx[4:0]];
`ifdef CMSDK_SWD_HOST_LINE_RESET_EN
            ST_LRST:  drv_o = 1'b1;
`endif
            default:  drv_o = 1'b0;
        endcase
    end

    // Main FSM: accept request, shift the packet bit by bit, hold the response.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            bit_q       <= '0;
            hdr_q       <= '0;
            rnw_q       <= 1'b0;
            wdata_q     <= '0;
            wpar_q      <= 1'b0;
            ack_q       <= '0;
            rdata_q     <= '0;
            rpar_q      <= 1'b0;
            swdio_o_q   <= 1'b0;
            swdio_oe_q  <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_ack_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_perr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        hdr_q      <= req_header(req_apndp, req_rnw, req_addr);
                        rnw_q      <= req_rnw;
                        wdata_q    <= req_wdata;
                        wpar_q     <= ^req_wdata;
                        ack_q      <= '0;
                        rdata_q    <= '0;
                        rpar_q     <= 1'b0;
                        bit_q      <= '0;
                        // Both the header start bit and line reset begin with a 1.
                        swdio_o_q  <= 1'b1;
                        swdio_oe_q <= 1'b1;
`ifdef CMSDK_SWD_HOST_LINE_RESET_EN
                        state_q    <= req_lrst ? ST_LRST : ST_REQ;
`else
                        state_q    <= ST_REQ;
`endif
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    if (rise_stb) begin
                        if (state_q == ST_ACK) begin
                            ack_q[bit_q[1:0]] <= swdio_i;
                        end else if (state_q == ST_RDATA) begin
                            if (bit_q == 6'd32) begin
                                rpar_q <= swdio_i;
                            end else begin
                                rdata_q[bit_q[4:0]] <= swdio_i;
                            end
                        end
                    end
                    if (fall_stb) begin
                        swdio_o_q  <= drv_o;
                        swdio_oe_q <= drv_oe;
                        if (last_bit) begin
                            state_q <= nxt_state;
                            bit_q   <= '0;
                            if (nxt_state == ST_RESP) begin
                                rsp_valid_q <= 1'b1;
                                rsp_ack_q   <= ack_q;
                                rsp_rdata_q <= read_ok ? rdata_q : 32'h0;
                                rsp_perr_q  <= read_ok ? ((^rdata_q) ^ rpar_q) : 1'b0;
                            end
                        end else begin
                            bit_q <= bit_q + 6'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
